// File: rtl/xlib_avalon_dma_rd_pkg.sv
// Shared types and helpers for the Avalon DMA read engine.
package xlib_avalon_dma_rd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StReq,
    StDrain,
    StDone
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/xlib_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count, depth 2^FW.
module xlib_sync_fifo #(
  parameter int unsigned DW = 32,
  parameter int unsigned FW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic [FW:0]   o_cnt
);

  localparam int unsigned FD = 1 << FW;

  logic [DW-1:0] r_mem [FD];
  logic [FW-1:0] r_wptr;
  logic [FW-1:0] r_rptr;
  logic [FW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && (r_cnt != (FW+1)'(FD));
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/xlib_avalon_dma_rd.sv
// Single-channel DMA read engine: splits a command into credit-limited Avalon
// bursts and streams the returned beats out through a local FIFO.
module xlib_avalon_dma_rd
  import xlib_avalon_dma_rd_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned BL   = 4,
  parameter int unsigned MAXB = 8,
  parameter int unsigned LW   = 16,
  parameter int unsigned FW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_val,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          m_rval,
  input  logic          m_rrdy,
  output logic [BL-1:0] m_rlen,
  output logic [AW-1:0] m_raddr,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_rdval,
  output logic          o_val,
  input  logic          o_rdy,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic          done,
  output logic          err
);

  localparam int unsigned FD  = 1 << FW;
  localparam int unsigned BSH = clog2(DW / 8);

  state_t        r_state;
  logic [LW-1:0] r_rem;
  logic [AW-1:0] r_addr;
  logic [FW:0]   r_outst;
  logic [LW-1:0] r_dcnt;
  logic [BL-1:0] r_rlen;
  logic [AW-1:0] r_raddr;
  logic          r_err;

  logic [FW:0]   w_cnt;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_acc;
  logic [FW+1:0] w_credit;
  logic [LW-1:0] w_len;
  logic [LW-1:0] w_dcnt_nxt;

  // Beats with nothing outstanding are dropped so they cannot corrupt the FIFO.
  assign w_push     = m_rdval && (r_outst != '0);
  assign w_pop      = o_val && o_rdy;
  assign w_acc      = (r_state == StReq) && m_rrdy;
  assign w_credit   = (FW+2)'(FD) - (FW+2)'(w_cnt) - (FW+2)'(r_outst);
  assign w_dcnt_nxt = w_pop ? r_dcnt - 1'b1 : r_dcnt;

  always_comb begin
    w_len = r_rem;
    if (w_len > LW'(MAXB))     w_len = LW'(MAXB);
    if (w_len > LW'(w_credit)) w_len = LW'(w_credit);
  end

  xlib_sync_fifo #(
    .DW (DW),
    .FW (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (m_rdata),
    .i_pop   (w_pop),
    .o_data  (o_data),
    .o_empty (w_empty),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_addr  <= '0;
      r_outst <= '0;
      r_dcnt  <= '0;
      r_rlen  <= '0;
      r_raddr <= '0;
      r_err   <= 1'b0;
    end else begin
      r_outst <= r_outst + (w_acc ? (FW+1)'(r_rlen) : '0) - (w_push ? (FW+1)'(1) : '0);
      if (m_rdval && (r_outst == '0)) r_err <= 1'b1;
      r_dcnt <= w_dcnt_nxt;
      unique case (r_state)
        StIdle: begin
          if (cmd_val) begin
            r_rem   <= cmd_len;
            r_dcnt  <= cmd_len;
            r_addr  <= cmd_addr;
            r_state <= (cmd_len != '0) ? StIssue : StDone;
          end
        end
        StIssue: begin
          if (r_rem == '0) begin
            r_state <= StDrain;
          end else if (w_credit != '0) begin
            r_rlen  <= BL'(w_len);
            r_raddr <= r_addr;
            r_state <= StReq;
          end
        end
        StReq: begin
          if (m_rrdy) begin
            r_rem   <= r_rem - LW'(r_rlen);
            r_addr  <= r_addr + (AW'(r_rlen) << BSH);
            r_state <= StIssue;
          end
        end
        // Finish as soon as the last pop lands so done follows it by one cycle.
        StDrain: if (w_dcnt_nxt == '0) r_state <= StDone;
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_rdy = (r_state == StIdle);
  assign m_rval  = (r_state == StReq);
  assign m_rlen  = r_rlen;
  assign m_raddr = r_raddr;
  assign done    = (r_state == StDone);
  assign err     = r_err;
  assign o_val   = !w_empty;
  assign o_last  = o_val && (r_dcnt == LW'(1));

endmodule

// File: tb/tb_xlib_avalon_dma_rd.sv
// Directed bench: bus/consumer models plus scoreboards for words and bursts.
module tb_xlib_avalon_dma_rd;

  logic        clk;
  logic        rst;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        m_rval;
  logic        m_rrdy;
  logic [3:0]  m_rlen;
  logic [31:0] m_raddr;
  logic [31:0] m_rdata;
  logic        m_rdval;
  logic        o_val;
  logic        o_rdy;
  logic [31:0] o_data;
  logic        o_last;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
  } burst_t;

  exp_t        exp_q[$];
  burst_t      exp_bq[$];
  logic [31:0] beat_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;
  int req_beats = 0;
  int done_cnt = 0;
  int acc_dly = 5;
  bit rrdy_en = 1;
  bit ret_en = 1;
  bit rdy_en = 1;
  bit check_bursts = 1;
  bit inject = 0;

  xlib_avalon_dma_rd dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .m_rval   (m_rval),
    .m_rrdy   (m_rrdy),
    .m_rlen   (m_rlen),
    .m_raddr  (m_raddr),
    .m_rdata  (m_rdata),
    .m_rdval  (m_rdval),
    .o_val    (o_val),
    .o_rdy    (o_rdy),
    .o_data   (o_data),
    .o_last   (o_last),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bus slave: returns one queued beat per cycle, accepts requests after acc_dly cycles.
  initial begin
    int wait_cnt;
    burst_t b;
    wait_cnt = 0;
    m_rrdy = 1'b0;
    m_rdval = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (inject) begin
        m_rdval = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        inject = 0;
      end else if (ret_en && beat_q.size() > 0) begin
        m_rdval = 1'b1;
        m_rdata = mem_f(beat_q.pop_front());
      end else begin
        m_rdval = 1'b0;
      end
      if (m_rval && !m_rrdy) begin
        wait_cnt++;
        if (rrdy_en && wait_cnt >= acc_dly) begin
          m_rrdy = 1'b1;
          wait_cnt = 0;
          req_cnt++;
          req_beats += int'(m_rlen);
          for (int i = 0; i < int'(m_rlen); i++) beat_q.push_back(m_raddr + 32'(i * 4));
          if (check_bursts) begin
            check("burst_expected", 64'(exp_bq.size() != 0), 64'(1));
            if (exp_bq.size() != 0) begin
              b = exp_bq.pop_front();
              check("burst_addr", 64'(m_raddr), 64'(b.addr));
              check("burst_len", 64'(m_rlen), 64'(b.len));
            end
          end
        end
      end else begin
        m_rrdy = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Stream consumer and scoreboard check.
  initial begin
    exp_t e;
    o_rdy = 1'b0;
    forever begin
      @(negedge clk);
      o_rdy = rdy_en;
      if (done) done_cnt++;
      if (o_val && o_rdy) begin
        check("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("o_data", 64'(o_data), 64'(e.data));
          check("o_last", 64'(o_last), 64'(e.last));
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
    int b = 0;
    while (!cmd_rdy && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("cmd_rdy_wait", 64'(cmd_rdy), 64'(1));
    cmd_addr = a;
    cmd_len  = n;
    cmd_val  = 1'b1;
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back('{data: mem_f(a + 32'(i * 4)), last: (i == int'(n) - 1)});
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (!done && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("done_seen", 64'(done), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    int b0;
    int k;
    rst = 1'b1;
    cmd_val = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    #1;
    check("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
    check("rst_m_rval", 64'(m_rval), 64'(0));
    check("rst_m_rlen", 64'(m_rlen), 64'(0));
    check("rst_m_raddr", 64'(m_raddr), 64'(0));
    check("rst_o_val", 64'(o_val), 64'(0));
    check("rst_o_last", 64'(o_last), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic 20-word transfer split 8/8/4.
    exp_bq.push_back('{addr: 32'h1000, len: 4'd8});
    exp_bq.push_back('{addr: 32'h1020, len: 4'd8});
    exp_bq.push_back('{addr: 32'h1040, len: 4'd4});
    d0 = done_cnt;
    send_cmd(32'h1000, 16'd20);
    wait_done(1000);
    @(negedge clk); #1;
    check("t1_words_left", 64'(exp_q.size()), 64'(0));
    check("t1_bursts_left", 64'(exp_bq.size()), 64'(0));
    check("t1_done_count", 64'(done_cnt - d0), 64'(1));
    check("t1_err", 64'(err), 64'(0));

    // Zero-length command.
    r0 = req_cnt;
    send_cmd(32'h5000, 16'd0);
    check("t2_done_t1", 64'(done), 64'(1));
    check("t2_cmd_rdy_t1", 64'(cmd_rdy), 64'(0));
    check("t2_m_rval_t1", 64'(m_rval), 64'(0));
    @(negedge clk); #1;
    check("t2_done_t2", 64'(done), 64'(0));
    check("t2_cmd_rdy_t2", 64'(cmd_rdy), 64'(1));
    check("t2_no_req", 64'(req_cnt - r0), 64'(0));

    // Backpressure: credit stops requests at FIFO depth.
    check_bursts = 0;
    rdy_en = 0;
    b0 = req_beats;
    send_cmd(32'h3000, 16'd40);
    repeat (120) @(negedge clk);
    #1;
    check("t3_beats_stalled", 64'(req_beats - b0), 64'(16));
    check("t3_o_val_held", 64'(o_val), 64'(1));
    check("t3_m_rval_low", 64'(m_rval), 64'(0));
    rdy_en = 1;
    wait_done(3000);
    @(negedge clk); #1;
    check("t3_beats_total", 64'(req_beats - b0), 64'(40));
    check("t3_words_left", 64'(exp_q.size()), 64'(0));
    check_bursts = 1;

    // Request held stable while m_rrdy stays low.
    rrdy_en = 0;
    exp_bq.push_back('{addr: 32'h2000, len: 4'd3});
    send_cmd(32'h2000, 16'd3);
    k = 0;
    while (!m_rval && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t4_m_rval", 64'(m_rval), 64'(1));
      check("t4_m_rlen", 64'(m_rlen), 64'(3));
      check("t4_m_raddr", 64'(m_raddr), 64'(32'h2000));
      @(negedge clk);
    end
    rrdy_en = 1;
    wait_done(500);

    // Address wrap at the top of the address space.
    exp_bq.push_back('{addr: 32'hFFFF_FFF8, len: 4'd4});
    send_cmd(32'hFFFF_FFF8, 16'd4);
    wait_done(500);
    @(negedge clk); #1;
    check("t5_bursts_left", 64'(exp_bq.size()), 64'(0));
    check("t5_words_left", 64'(exp_q.size()), 64'(0));
    check("t5_err", 64'(err), 64'(0));

    // Spurious beat while idle.
    inject = 1;
    repeat (2) @(negedge clk);
    #1;
    check("t6_err_set", 64'(err), 64'(1));
    check("t6_no_o_val", 64'(o_val), 64'(0));

    // Reset in the middle of a transfer.
    check_bursts = 0;
    rdy_en = 0;
    send_cmd(32'h4000, 16'd20);
    repeat (30) @(negedge clk);
    #1;
    check("t7_pre_o_val", 64'(o_val), 64'(1));
    rrdy_en = 0;
    ret_en = 0;
    #2;
    rst = 1'b1;
    #1;
    check("t7_cmd_rdy", 64'(cmd_rdy), 64'(1));
    check("t7_m_rval", 64'(m_rval), 64'(0));
    check("t7_m_rlen", 64'(m_rlen), 64'(0));
    check("t7_m_raddr", 64'(m_raddr), 64'(0));
    check("t7_o_val", 64'(o_val), 64'(0));
    check("t7_o_last", 64'(o_last), 64'(0));
    check("t7_done", 64'(done), 64'(0));
    check("t7_err", 64'(err), 64'(0));
    beat_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
